adc_readout_serializer: RTL and testbench

- Downstream stage of the ADC capture/averaging controller.
- Consumes its 128-bit CPU-readout stream (8 x 16-bit samples per beat) and serialises it to a 32-bit AXI-Stream toward the CPU DMA path.
- Generates tlast framing every programmable number of input beats and counts completed frames.
- Backpressure propagates upstream so the controller's data FIFO drains only as fast as the CPU accepts.

---
 rtl/adc_readout_serializer.sv | 145 ++++++++++++++
 tb/tb_adc_readout_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_serializer.sv
// 128->32 readout serializer with tlast framing and completed-frame count; ADC_READOUT_HEADER_EN adds a per-frame header word.
// Latency: a beat accepted at cycle N presents lane0 (or the header) at N+1, then one word per accepted cycle.
// Backpressure: s_axis_tready is high only when the holding register is empty or its lane3 transfers this cycle.
module adc_readout_serializer #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32,
   parameter int CNT_W = 32,
   parameter int FRM_W = 16
) (
   input  logic             rf_clk,
   input  logic             rf_reset,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   input  logic [CNT_W-1:0] frame_len,
   output logic             frame_done,
   output logic [FRM_W-1:0] frames_sent
);

`ifdef ADC_READOUT_HEADER_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, HDR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

   state_t            state;
   logic [IN_W-1:0]   hold_dat;
   logic              hold_valid;
   logic [1:0]        lane;
   logic [CNT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]  len_latched;

   logic              out_xfer;
   logic              lane3_xfer;
   logic              in_xfer;
   logic              is_last;

   assign out_xfer   = m_axis_tvalid & m_axis_tready;
   assign lane3_xfer = out_xfer & (lane == 2'd3) & (state == DATA);
   assign in_xfer    = s_axis_tvalid & s_axis_tready;
   assign is_last    = (lane == 2'd3) & (len_latched != '0) & (beat_cnt == len_latched);

   // Gating with the reset keeps the upstream FIFO from being popped while we are held in reset.
   assign s_axis_tready = rf_reset & (~hold_valid | lane3_xfer);
   assign m_axis_tlast  = (state == DATA) & hold_valid & is_last;

`ifdef ADC_READOUT_HEADER_EN
   assign m_axis_tvalid = hold_valid & ((state == DATA) | (state == HDR));
`else
   assign m_axis_tvalid = hold_valid & (state == DATA);
`endif

   always_comb begin
      m_axis_tdata = hold_dat[OUT_W-1:0];
      case (lane)
         2'd1:    m_axis_tdata = hold_dat[2*OUT_W-1:OUT_W];
         2'd2:    m_axis_tdata = hold_dat[3*OUT_W-1:2*OUT_W];
         2'd3:    m_axis_tdata = hold_dat[4*OUT_W-1:3*OUT_W];
         default: m_axis_tdata = hold_dat[OUT_W-1:0];
      endcase
`ifdef ADC_READOUT_HEADER_EN
      if (state == HDR) begin
         m_axis_tdata = OUT_W'({8'hA5, 8'h00, frames_sent[15:0]});
      end
`endif
   end

   always_ff @(posedge rf_clk or negedge rf_reset) begin
      if (!rf_reset) begin
         state       <= IDLE;
         hold_dat    <= '0;
         hold_valid  <= 1'b0;
         lane        <= 2'd0;
         beat_cnt    <= '0;
         len_latched <= '0;
         frames_sent <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  hold_dat    <= s_axis_tdata;
                  hold_valid  <= 1'b1;
                  lane        <= 2'd0;
                  len_latched <= frame_len;
                  beat_cnt    <= CNT_W'(1);
`ifdef ADC_READOUT_HEADER_EN
                  state       <= HDR;
`else
                  state       <= DATA;
`endif
               end
            end
`ifdef ADC_READOUT_HEADER_EN
            HDR: begin
               if (out_xfer) begin
                  state <= DATA;
               end
            end
`endif
            DATA: begin
               if (out_xfer) begin
                  lane <= lane + 2'd1;
               end
               if (lane3_xfer && is_last) begin
                  frame_done  <= 1'b1;
                  frames_sent <= frames_sent + FRM_W'(1);
                  // A beat accepted alongside the tlast word opens the next frame directly.
                  if (in_xfer) begin
                     hold_dat    <= s_axis_tdata;
                     lane        <= 2'd0;
                     len_latched <= frame_len;
                     beat_cnt    <= CNT_W'(1);
`ifdef ADC_READOUT_HEADER_EN
                     state       <= HDR;
`else
                     state       <= DATA;
`endif
                  end else begin
                     hold_valid <= 1'b0;
                     beat_cnt   <= '0;
                     state      <= IDLE;
                  end
               end else if (in_xfer) begin
                  hold_dat   <= s_axis_tdata;
                  hold_valid <= 1'b1;
                  lane       <= 2'd0;
                  if (beat_cnt != '1) begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end else if (lane3_xfer) begin
                  hold_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_readout_serializer.sv
// Directed bench for adc_readout_serializer: expected words are queued when beats are driven and checked as they leave.
module tb_adc_readout_serializer;
   localparam int IN_W  = 128;
   localparam int OUT_W = 32;
   localparam int CNT_W = 32;
   localparam int FRM_W = 16;

   logic             rf_clk = 1'b0;
   logic             rf_reset = 1'b0;
   logic [IN_W-1:0]  s_axis_tdata = '0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic [OUT_W-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b1;
   logic             m_axis_tlast;
   logic [CNT_W-1:0] frame_len = '0;
   logic             frame_done;
   logic [FRM_W-1:0] frames_sent;

   adc_readout_serializer #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .FRM_W(FRM_W)
   ) dut (
      .rf_clk(rf_clk),
      .rf_reset(rf_reset),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .frame_len(frame_len),
      .frame_done(frame_done),
      .frames_sent(frames_sent)
   );

   always #5 rf_clk = ~rf_clk;

   typedef struct packed {
      logic [31:0] dat;
      logic        last;
      logic        hdr;
      logic [1:0]  lane;
   } exp_t;

   exp_t sb[$];
   exp_t head;

   int n_checks = 0;
   int n_err = 0;
   int n_pushed = 0;
   int done_seen = 0;
   int done_exp = 0;
   int mdl_cnt = 0;
   logic [31:0] mdl_len = '0;
   logic [15:0] mdl_frames = '0;

   bit toggle_en = 1'b0;
   logic rdy_level = 1'b1;

   int cyc = 0;
   int xfer_total = 0;
   int mark = -1;
   int first_cyc = 0;
   int last_cyc = 0;
   bit prev_stall = 1'b0;
   logic [31:0] prev_dat = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [127:0] make_beat(input int base);
      logic [127:0] b;
      b = '0;
      for (int k = 0; k < 8; k++) b[16*k +: 16] = 16'(base + k);
      return b;
   endfunction

   task automatic push_beat(input logic [127:0] d);
      exp_t e;
      if (mdl_cnt == 0) begin
         mdl_len = frame_len;
`ifdef ADC_READOUT_HEADER_EN
         e.dat = {8'hA5, 8'h00, mdl_frames};
         e.last = 1'b0;
         e.hdr = 1'b1;
         e.lane = 2'd0;
         sb.push_back(e);
         n_pushed++;
`endif
      end
      mdl_cnt++;
      for (int l = 0; l < 4; l++) begin
         e.dat = d[32*l +: 32];
         e.hdr = 1'b0;
         e.lane = 2'(l);
         e.last = (l == 3) && (mdl_len != 0) && (mdl_cnt == int'(mdl_len));
         sb.push_back(e);
         n_pushed++;
      end
      if (mdl_len != 0 && mdl_cnt == int'(mdl_len)) begin
         mdl_cnt = 0;
         mdl_frames++;
         done_exp++;
      end
   endtask

   // Leaves tvalid high so consecutive calls present beats back to back.
   task automatic send_beat(input logic [127:0] d);
      bit acc;
      int waited;
      acc = 1'b0;
      waited = 0;
      push_beat(d);
      s_axis_tdata = d;
      s_axis_tvalid = 1'b1;
      while (!acc && waited < 300) begin
         @(negedge rf_clk);
         acc = s_axis_tready;
         @(posedge rf_clk);
         #1;
         waited++;
      end
      check("beat_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 1000) begin
         @(posedge rf_clk);
         w++;
      end
      check("drain_queue_empty", 32'(sb.size()), 32'd0);
      repeat (3) @(posedge rf_clk);
      #1;
   endtask

   always @(posedge rf_clk) begin
      cyc++;
      #1;
      if (toggle_en) m_axis_tready = ~m_axis_tready;
      else m_axis_tready = rdy_level;
   end

   always @(negedge rf_clk) begin
      if (!rf_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_tvalid_held", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata_held", m_axis_tdata, prev_dat);
         end
         if (frame_done) done_seen++;
         if (m_axis_tvalid) begin
            if (sb.size() == 0) begin
               check("extra_word_queue_depth", 32'(sb.size()), 32'd1);
            end else begin
               head = sb[0];
               check("s_tready", 32'(s_axis_tready),
                     head.hdr ? 32'd0 : 32'((head.lane == 2'd3) && m_axis_tready));
               if (m_axis_tready) begin
                  void'(sb.pop_front());
                  check("tdata", m_axis_tdata, head.dat);
                  check("tlast", 32'(m_axis_tlast), 32'(head.last));
                  if (xfer_total == mark) first_cyc = cyc;
                  last_cyc = cyc;
                  xfer_total++;
               end
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_dat = m_axis_tdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed0;
      repeat (3) @(posedge rf_clk);
      #1;
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_frames_sent", 32'(frames_sent), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      rf_reset = 1'b1;
      @(posedge rf_clk);
      #1;

      // single two-beat frame
      frame_len = 32'd2;
      send_beat(make_beat(0));
      send_beat(make_beat(8));
      s_axis_tvalid = 1'b0;
      drain();
      check("single_frames_sent", 32'(frames_sent), 32'd1);
      check("single_frame_done", 32'(done_seen), 32'(done_exp));

      // toggling ready; frame_len change after the first beat must not affect this frame
      toggle_en = 1'b1;
      frame_len = 32'd4;
      send_beat(make_beat(16));
      frame_len = 32'd1;
      send_beat(make_beat(24));
      send_beat(make_beat(32));
      send_beat(make_beat(40));
      s_axis_tvalid = 1'b0;
      drain();
      toggle_en = 1'b0;
      rdy_level = 1'b1;
      check("bp_frames_sent", 32'(frames_sent), 32'd2);

      // back-to-back: one word per cycle
      frame_len = 32'd4;
      mark = xfer_total;
      pushed0 = n_pushed;
      for (int i = 0; i < 16; i++) send_beat(make_beat(100 + 8 * i));
      s_axis_tvalid = 1'b0;
      drain();
      check("b2b_consecutive_span", 32'(last_cyc - first_cyc), 32'(n_pushed - pushed0 - 1));
      check("b2b_frames_sent", 32'(frames_sent), 32'd6);
      check("b2b_frame_done", 32'(done_seen), 32'(done_exp));

      // unframed
      frame_len = 32'd0;
      for (int i = 0; i < 10; i++) send_beat(make_beat(500 + 8 * i));
      s_axis_tvalid = 1'b0;
      drain();
      check("unframed_frames_sent", 32'(frames_sent), 32'd6);

      // clean reset, then reset after lane1 of a beat
      rf_reset = 1'b0;
      @(posedge rf_clk);
      #1;
      rf_reset = 1'b1;
      mdl_cnt = 0;
      mdl_frames = '0;
      frame_len = 32'd2;
      send_beat(make_beat(1000));
      s_axis_tvalid = 1'b0;
      @(posedge rf_clk);
      @(posedge rf_clk);
`ifdef ADC_READOUT_HEADER_EN
      @(posedge rf_clk);
`endif
      #1;
      rf_reset = 1'b0;
      #1;
      check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
      check("midrst_frames_sent", 32'(frames_sent), 32'd0);
      check("midrst_words_left", 32'(sb.size()), 32'd2);
      sb.delete();
      mdl_cnt = 0;
      mdl_frames = '0;
      @(posedge rf_clk);
      #1;
      rf_reset = 1'b1;
      frame_len = 32'd1;
      send_beat(make_beat(2000));
      s_axis_tvalid = 1'b0;
      drain();
      check("postrst_frames_sent", 32'(frames_sent), 32'd1);

      // single-beat frames up to frames_sent=5, then one more (header 0xA500_0005 when enabled)
      for (int i = 0; i < 5; i++) send_beat(make_beat(3000 + 8 * i));
      s_axis_tvalid = 1'b0;
      drain();
      check("final_frames_sent", 32'(frames_sent), 32'd6);
      check("final_frame_done", 32'(done_seen), 32'(done_exp));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
